// File: rtl/instruction_decode_pkg.sv
// -----------------------------------------------------------------------------
// instruction_decode_pkg
//   Shared definitions for the LEGv8 decode stage: datapath widths, the XZR
//   index, opcode prefixes, ALUSrc/ALUOp encodings, the control bundle carried
//   into the ID/EX register, and two helpers (opcode classification and
//   immediate sign extension).
//   Configuration macro: WB_BYPASS_EN (consumed by the register file and the
//   hazard unit, not by this package).
// -----------------------------------------------------------------------------
package instruction_decode_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam logic [4:0] ZERO_REG = 5'd31;

  // Opcode prefixes, compared against the top bits of the instruction word
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  // ALUSrc: which operand feeds ALU input 2
  localparam logic [1:0] ALU_SRC_REG   = 2'b00;
  localparam logic [1:0] ALU_SRC_SEXT  = 2'b01;
  localparam logic [1:0] ALU_SRC_IMM12 = 2'b10;

  // ALUOp: add / pass input 2 / decode from opcode
  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_PASS = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC = 2'b10;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_R       = 3'd1,
    CLS_I       = 3'd2,
    CLS_LDUR    = 3'd3,
    CLS_STUR    = 3'd4,
    CLS_CBZ     = 3'd5,
    CLS_CBNZ    = 3'd6,
    CLS_B       = 3'd7
  } instr_class_e;

  typedef struct packed {
    logic       b;
    logic       bz;
    logic       bnz;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Map the instruction word onto one of the supported formats
  function automatic instr_class_e classify(input logic [31:0] instr);
    instr_class_e cls;
    if ((instr[31:21] == OP_ADD) || (instr[31:21] == OP_SUB) ||
        (instr[31:21] == OP_AND) || (instr[31:21] == OP_ORR)) begin
      cls = CLS_R;
    end else if ((instr[31:22] == OP_ADDI) || (instr[31:22] == OP_SUBI)) begin
      cls = CLS_I;
    end else if (instr[31:21] == OP_LDUR) begin
      cls = CLS_LDUR;
    end else if (instr[31:21] == OP_STUR) begin
      cls = CLS_STUR;
    end else if (instr[31:24] == OP_CBZ) begin
      cls = CLS_CBZ;
    end else if (instr[31:24] == OP_CBNZ) begin
      cls = CLS_CBNZ;
    end else if (instr[31:26] == OP_B) begin
      cls = CLS_B;
    end else begin
      cls = CLS_ILLEGAL;
    end
    return cls;
  endfunction

  // Immediate field per format; I-format uses the raw 12-bit field via ALUSrc=10
  function automatic logic [XLEN-1:0] sign_extend(input logic [31:0] instr,
                                                  input instr_class_e cls);
    logic [XLEN-1:0] ext;
    case (cls)
      CLS_LDUR, CLS_STUR: ext = {{55{instr[20]}}, instr[20:12]};
      CLS_CBZ, CLS_CBNZ:  ext = {{45{instr[23]}}, instr[23:5]};
      CLS_B:              ext = {{38{instr[25]}}, instr[25:0]};
      default:            ext = 64'd0;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/instruction_decode_reg_file_2r1w.sv
// -----------------------------------------------------------------------------
// reg_file_2r1w
//   32 x 64 architectural register file: two asynchronous read ports, one
//   synchronous write port. Register 31 (XZR) always reads zero and ignores
//   writes.
//   Configuration macro: WB_BYPASS_EN -- when defined, a read of the register
//   being written this cycle returns the write data (write-through).
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset (clears all entries)
//   i_we/i_waddr/i_wdata  write port
//   i_raddr1/o_rdata1     read port 1
//   i_raddr2/o_rdata2     read port 2
// -----------------------------------------------------------------------------
module reg_file_2r1w
  import instruction_decode_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_raddr1,
  output logic [XLEN-1:0] o_rdata1,
  input  logic [4:0]      i_raddr2,
  output logic [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] r_regs [NREG];

  // Storage: cleared on reset, written on rising edge unless the target is XZR
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= 64'd0;
      end
    end else if (i_we && (i_waddr != ZERO_REG)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read port 1
  always_comb begin
    if (i_raddr1 == ZERO_REG) begin
      o_rdata1 = 64'd0;
`ifdef WB_BYPASS_EN
    end else if (i_we && (i_waddr == i_raddr1)) begin
      o_rdata1 = i_wdata;
`endif
    end else begin
      o_rdata1 = r_regs[i_raddr1];
    end
  end

  // Read port 2
  always_comb begin
    if (i_raddr2 == ZERO_REG) begin
      o_rdata2 = 64'd0;
`ifdef WB_BYPASS_EN
    end else if (i_we && (i_waddr == i_raddr2)) begin
      o_rdata2 = i_wdata;
`endif
    end else begin
      o_rdata2 = r_regs[i_raddr2];
    end
  end

endmodule

// File: rtl/instruction_decode.sv
// -----------------------------------------------------------------------------
// instruction_decode
//   LEGv8 decode stage: register file, main control decoder, sign extension,
//   load-use hazard detection and the ID/EX pipeline register.
//   Configuration macro: WB_BYPASS_EN -- when defined, register reads see the
//   writeback value in the same cycle; when undefined, a decode that reads the
//   register being written back stalls one cycle instead.
// Ports:
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_if_valid, i_if_pc, i_if_instr     instruction from fetch
//   i_flush                             kill the instruction in decode
//   i_wb_reg_write, i_wb_reg, i_wb_data writeback port
//   o_stall_if                          hold PC and IF/ID (combinational)
//   o_illegal_instr                     one-cycle pulse: undecodable opcode dropped
//   o_ex_*                              registered ID/EX contents
// -----------------------------------------------------------------------------
module instruction_decode
  import instruction_decode_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_if_valid,
  input  logic [XLEN-1:0] i_if_pc,
  input  logic [31:0]     i_if_instr,
  input  logic            i_flush,
  input  logic            i_wb_reg_write,
  input  logic [4:0]      i_wb_reg,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_stall_if,
  output logic            o_illegal_instr,
  output logic            o_ex_valid,
  output logic [XLEN-1:0] o_ex_address,
  output logic [31:0]     o_ex_instruction,
  output logic [XLEN-1:0] o_ex_sign_ext,
  output logic [XLEN-1:0] o_ex_data1,
  output logic [XLEN-1:0] o_ex_data2,
  output logic [1:0]      o_ex_alu_src,
  output logic [1:0]      o_ex_alu_op,
  output logic            o_ex_b,
  output logic            o_ex_bz,
  output logic            o_ex_bnz,
  output logic            o_ex_mem_write,
  output logic            o_ex_mem_read,
  output logic            o_ex_mem_to_reg,
  output logic            o_ex_reg_write
);

  instr_class_e    w_class;
  ctrl_t           w_ctrl;
  logic            w_use_rn;
  logic            w_use_rd2;
  logic [4:0]      w_rn;
  logic [4:0]      w_rd2_addr;
  logic [XLEN-1:0] w_sign_ext;
  logic [XLEN-1:0] w_rdata1;
  logic [XLEN-1:0] w_rdata2;
  logic [4:0]      w_ex_rd;
  logic            w_ld_hazard;
  logic            w_wb_hazard;
  logic            w_hazard;
  logic            w_issue;
  logic            w_illegal;

  logic            r_ex_valid;
  logic [XLEN-1:0] r_ex_address;
  logic [31:0]     r_ex_instruction;
  logic [XLEN-1:0] r_ex_sign_ext;
  logic [XLEN-1:0] r_ex_data1;
  logic [XLEN-1:0] r_ex_data2;
  ctrl_t           r_ex_ctrl;
  logic            r_illegal;

  assign w_class    = classify(i_if_instr);
  assign w_sign_ext = sign_extend(i_if_instr, w_class);
  assign w_rn       = i_if_instr[9:5];
  // Port 2 reads Rm for R-type and Rt for everything else (STUR/CBZ/CBNZ)
  assign w_rd2_addr = (w_class == CLS_R) ? i_if_instr[20:16] : i_if_instr[4:0];

  reg_file_2r1w u_reg_file (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_we     (i_wb_reg_write),
    .i_waddr  (i_wb_reg),
    .i_wdata  (i_wb_data),
    .i_raddr1 (w_rn),
    .o_rdata1 (w_rdata1),
    .i_raddr2 (w_rd2_addr),
    .o_rdata2 (w_rdata2)
  );

  // Main control decoder plus which read ports the instruction really consumes
  always_comb begin
    w_ctrl    = CTRL_NOP;
    w_use_rn  = 1'b0;
    w_use_rd2 = 1'b0;
    case (w_class)
      CLS_R: begin
        w_ctrl.alu_src   = ALU_SRC_REG;
        w_ctrl.alu_op    = ALU_OP_FUNC;
        w_ctrl.reg_write = 1'b1;
        w_use_rn         = 1'b1;
        w_use_rd2        = 1'b1;
      end
      CLS_I: begin
        w_ctrl.alu_src   = ALU_SRC_IMM12;
        w_ctrl.alu_op    = ALU_OP_FUNC;
        w_ctrl.reg_write = 1'b1;
        w_use_rn         = 1'b1;
      end
      CLS_LDUR: begin
        w_ctrl.alu_src    = ALU_SRC_SEXT;
        w_ctrl.alu_op     = ALU_OP_ADD;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_use_rn          = 1'b1;
      end
      CLS_STUR: begin
        w_ctrl.alu_src   = ALU_SRC_SEXT;
        w_ctrl.alu_op    = ALU_OP_ADD;
        w_ctrl.mem_write = 1'b1;
        w_use_rn         = 1'b1;
        w_use_rd2        = 1'b1;
      end
      CLS_CBZ: begin
        w_ctrl.alu_src = ALU_SRC_REG;
        w_ctrl.alu_op  = ALU_OP_PASS;
        w_ctrl.bz      = 1'b1;
        w_use_rd2      = 1'b1;
      end
      CLS_CBNZ: begin
        w_ctrl.alu_src = ALU_SRC_REG;
        w_ctrl.alu_op  = ALU_OP_PASS;
        w_ctrl.bnz     = 1'b1;
        w_use_rd2      = 1'b1;
      end
      CLS_B: begin
        w_ctrl.alu_op = ALU_OP_PASS;
        w_ctrl.b      = 1'b1;
      end
      default: begin
        w_ctrl = CTRL_NOP;
      end
    endcase
  end

  // Load-use: the load in EX writes its Rt, which this instruction needs now
  assign w_ex_rd     = r_ex_instruction[4:0];
  assign w_ld_hazard = r_ex_valid && r_ex_ctrl.mem_read && (w_ex_rd != ZERO_REG) &&
                       ((w_use_rn && (w_ex_rd == w_rn)) ||
                        (w_use_rd2 && (w_ex_rd == w_rd2_addr)));

`ifdef WB_BYPASS_EN
  assign w_wb_hazard = 1'b0;
`else
  // Without write-through the read would see stale data: wait one cycle
  assign w_wb_hazard = i_wb_reg_write && (i_wb_reg != ZERO_REG) &&
                       ((w_use_rn && (i_wb_reg == w_rn)) ||
                        (w_use_rd2 && (i_wb_reg == w_rd2_addr)));
`endif

  assign w_hazard   = i_if_valid && (w_ld_hazard || w_wb_hazard);
  // Flush overrides stall and illegal reporting
  assign o_stall_if = w_hazard && !i_flush;
  assign w_illegal  = i_if_valid && !i_flush && (w_class == CLS_ILLEGAL);
  assign w_issue    = i_if_valid && !i_flush && !w_hazard && (w_class != CLS_ILLEGAL);

  // ID/EX register: load the decoded instruction or a fully cleared bubble
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex_valid       <= 1'b0;
      r_ex_address     <= 64'd0;
      r_ex_instruction <= 32'd0;
      r_ex_sign_ext    <= 64'd0;
      r_ex_data1       <= 64'd0;
      r_ex_data2       <= 64'd0;
      r_ex_ctrl        <= CTRL_NOP;
      r_illegal        <= 1'b0;
    end else begin
      r_illegal <= w_illegal;
      if (w_issue) begin
        r_ex_valid       <= 1'b1;
        r_ex_address     <= i_if_pc;
        r_ex_instruction <= i_if_instr;
        r_ex_sign_ext    <= w_sign_ext;
        r_ex_data1       <= w_rdata1;
        r_ex_data2       <= w_rdata2;
        r_ex_ctrl        <= w_ctrl;
      end else begin
        r_ex_valid       <= 1'b0;
        r_ex_address     <= 64'd0;
        r_ex_instruction <= 32'd0;
        r_ex_sign_ext    <= 64'd0;
        r_ex_data1       <= 64'd0;
        r_ex_data2       <= 64'd0;
        r_ex_ctrl        <= CTRL_NOP;
      end
    end
  end

  assign o_illegal_instr  = r_illegal;
  assign o_ex_valid       = r_ex_valid;
  assign o_ex_address     = r_ex_address;
  assign o_ex_instruction = r_ex_instruction;
  assign o_ex_sign_ext    = r_ex_sign_ext;
  assign o_ex_data1       = r_ex_data1;
  assign o_ex_data2       = r_ex_data2;
  assign o_ex_alu_src     = r_ex_ctrl.alu_src;
  assign o_ex_alu_op      = r_ex_ctrl.alu_op;
  assign o_ex_b           = r_ex_ctrl.b;
  assign o_ex_bz          = r_ex_ctrl.bz;
  assign o_ex_bnz         = r_ex_ctrl.bnz;
  assign o_ex_mem_write   = r_ex_ctrl.mem_write;
  assign o_ex_mem_read    = r_ex_ctrl.mem_read;
  assign o_ex_mem_to_reg  = r_ex_ctrl.mem_to_reg;
  assign o_ex_reg_write   = r_ex_ctrl.reg_write;

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Decode stage of the 5-stage LEGv8 pipeline. Sits between instruction fetch and the execution stage; feeds the execution stage's inputs directly.
- Contains:
  - the 32x64 register file
  - the main control decoder
  - sign extension
  - load-use hazard detection
  - the ID/EX pipeline register, with stall and flush

Parameters:
- XLEN, 64, datapath and register width.
- NREG, 32, number of architectural registers.
- ZERO_REG, 31, index of XZR. It always reads 0 and writes to it are discarded.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  if_pc/if_instr hold a real instruction
- if_pc  in  64  address of the fetched instruction
- if_instr  in  32  fetched instruction
- flush  in  1  taken branch (PCSrc from memory stage); kill instruction in decode
- wb_reg_write  in  1  writeback enable
- wb_reg  in  5  writeback destination
- wb_data  in  64  writeback value
- stall_if  out  1  hold PC and IF/ID this cycle (combinational)
- illegal_instr  out  1  registered one-cycle pulse: undecodable opcode was dropped
- ex_valid  out  1  ID/EX entry valid
- ex_address  out  64  registered if_pc
- ex_instruction  out  32  registered if_instr
- ex_sign_ext  out  64  registered sign-extended immediate
- ex_data1, ex_data2  out  64 each  registered register reads
- ex_alu_src  out  2  00 register, 01 sign-ext, 10 Instruction[21:10]
- ex_alu_op  out  2  00 add, 01 pass input2, 10 opcode-decoded
- ex_b, ex_bz, ex_bnz, ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_reg_write  out  1 each  control flags

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; ex_valid=0.
  - All registers cleared to 0.
  - Holds until rst_n rises. Reset mid-stall or mid-flush discards everything.
- Latency: one cycle. An instruction presented with if_valid and no stall appears on ex_* at the next rising edge.
- Decode (by if_instr[31:21] prefix):
  - R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000): alu_src 00, alu_op 10, reg_write.
  - ADDI 1001000100x, SUBI 1101000100x: alu_src 10, alu_op 10, reg_write.
  - LDUR 11111000010: alu_src 01, alu_op 00, mem_read, mem_to_reg, reg_write.
  - STUR 11111000000: alu_src 01, alu_op 00, mem_write.
  - CBZ 10110100, CBNZ 10110101: alu_src 00, alu_op 01, bz or bnz.
  - B 000101: b; alu_op 01.
  - Anything else: bubble plus illegal_instr pulse.
- Read port 2 address:
  - Rm = instr[20:16] for R-type.
  - Rt = instr[4:0] for STUR, CBZ and CBNZ.
- Port 1 address is Rn = instr[9:5].
- Sign extension:
  - D-format: instr[20:12] (9 bits).
  - CB: instr[23:5] (19 bits).
  - B: instr[25:0] (26 bits).
  - I-format and R-type: 0.
- Register file: written at the rising edge when wb_reg_write=1 and wb_reg≠ZERO_REG.
- Load-use hazard:
  - Condition: ex_valid & ex_mem_read, ex_instruction[4:0]≠31, and it equals a source actually used by the decoding instruction.
  - Response: stall_if=1; the ID/EX register loads a bubble (ex_valid=0, all control 0); the decoding instruction is re-presented next cycle.
- Flush:
  - ID/EX loads a bubble, stall_if=0, and no illegal_instr pulse.
  - Flush takes priority over stall and illegal.
- if_valid=0: bubble.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: a read whose address matches wb_reg, with wb_reg_write=1 and address≠31, returns wb_data in the same cycle (write-through).
- Undefined: reads return pre-write contents. The hazard unit additionally stalls (same bubble rules) while wb_reg_write=1 and wb_reg matches a used source ≠31.

Decomposition:
- Shared package holds:
  - opcode constants
  - ALUSrc/ALUOp encodings
  - XLEN
  - ZERO_REG
  - the control-bundle struct (b, bz, bnz, mem_write, mem_read, mem_to_reg, reg_write, alu_src, alu_op)
- One natural sub-module: reg_file_2r1w (two async reads, one sync write, XZR handling, optional bypass).

Test Plan:
- Reset, then write X1=0x10 and X2=0x20 via wb. Decode ADD X3,X1,X2 -> next cycle ex_data1=0x10, ex_data2=0x20, alu_op=10, reg_write=1, ex_valid=1.
- LDUR X5,[X1,#8] followed by ADD X6,X5,X2 -> cycle 2: stall_if=1 and a bubble. Cycle 3: ADD is issued with ex_valid=1.
- CBZ X7,#-4 -> ex_sign_ext=0xFFFF_FFFF_FFFF_FFFC, bz=1, ex_data2=X7.
- flush=1 asserted during a hazard stall -> ex_valid=0, stall_if=0, illegal_instr=0.
- Write X31=0x55, then read X31 -> 0. Opcode 0x00000000 -> illegal_instr pulse and a bubble.
- With WB_BYPASS_EN: wb X4=0x99 in the same cycle as decoding ADD X8,X4,X4 -> ex_data1=ex_data2=0x99. Without it: one stall, then 0x99.
